// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM state, owner tag and the
// muxed memory-request bundle.
package dmem_pkg;

    localparam int unsigned DMEM_AW = 32;
    localparam int unsigned DMEM_DW = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StDrain = 2'd2
    } dmem_state_e;

    typedef enum logic {
        OwnCore = 1'b0,
        OwnLd   = 1'b1
    } dmem_owner_e;

    typedef struct packed {
        logic               en;
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } dmem_req_t;

    function automatic dmem_req_t dmem_access(input logic               we,
                                               input logic [DMEM_AW-1:0] addr,
                                               input logic [DMEM_DW-1:0] wdata);
        dmem_req_t r;
        r.en    = 1'b1;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/dmem_burst_gen.sv
// Loader burst address generator: holds the burst base, the index of the next
// beat and the number of beats still to issue after beat 0.
module dmem_burst_gen
    import dmem_pkg::*;
#(
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [DMEM_AW-1:0] base_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               step_i,
    input  logic               clear_i,
    output logic [DMEM_AW-1:0] beat_addr_o,
    output logic               last_o
);

    logic [DMEM_AW-1:0] base_q, base_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   rem_q, rem_d;

    // Beat 0 goes out in the load cycle, so the counters start at beat 1.
    always_comb begin
        base_d = base_q;
        idx_d  = idx_q;
        rem_d  = rem_q;
        if (clear_i) begin
            base_d = '0;
            idx_d  = '0;
            rem_d  = '0;
        end else if (load_i) begin
            base_d = base_i;
            idx_d  = LEN_W'(1);
            rem_d  = len_i - LEN_W'(1);
        end else if (step_i) begin
            idx_d  = idx_q + LEN_W'(1);
            rem_d  = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
        end else begin
            base_q <= base_d;
            idx_q  <= idx_d;
            rem_q  <= rem_d;
        end
    end

    assign beat_addr_o = base_q + DMEM_AW'(idx_q) * DMEM_AW'(ADDR_STEP);
    assign last_o      = (rem_q == LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core (single beats) and the loader
// (bursts), with starvation guard, read-data steering and core stall.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [DMEM_AW-1:0] core_addr_i,
    input  logic [DMEM_DW-1:0] core_wdata_i,
    output logic               core_gnt_o,
    output logic               core_stall_o,
    output logic               core_rvalid_o,
    output logic [DMEM_DW-1:0] core_rdata_o,
    input  logic               ld_req_i,
    input  logic               ld_we_i,
    input  logic [DMEM_AW-1:0] ld_addr_i,
    input  logic [LEN_W-1:0]   ld_len_i,
    input  logic [DMEM_DW-1:0] ld_wdata_i,
    output logic               ld_gnt_o,
    output logic               ld_rvalid_o,
    output logic [DMEM_DW-1:0] ld_rdata_o,
    output logic               ld_done_o,
    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [DMEM_AW-1:0] mem_addr_o,
    output logic [DMEM_DW-1:0] mem_wdata_o,
    input  logic [DMEM_DW-1:0] mem_rdata_i
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    dmem_state_e        state_q, state_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic               dir_q, dir_d;
    logic               rd_pend_q, rd_pend_d;
    dmem_owner_e        owner_q, owner_d;

    logic               core_gnt, ld_gnt, ld_done;
    dmem_req_t          mem_req;
    logic               gen_load, gen_step, gen_clear;
    logic [DMEM_AW-1:0] gen_addr;
    logic               gen_last;
    logic [LEN_W-1:0]   ld_len_eff;
    logic               starve_hit;
    logic               ld_win;

    assign ld_len_eff = (ld_len_i == '0) ? LEN_W'(1) : ld_len_i;
    assign starve_hit = (starve_q == SW'(STARVE_MAX));
    assign ld_win     = ld_req_i & (~core_req_i | starve_hit);

    dmem_burst_gen #(
        .LEN_W     (LEN_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_burst_gen (
        .clk         (clk),
        .reset       (reset),
        .load_i      (gen_load),
        .base_i      (ld_addr_i),
        .len_i       (ld_len_eff),
        .step_i      (gen_step),
        .clear_i     (gen_clear),
        .beat_addr_o (gen_addr),
        .last_o      (gen_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ld_win) begin
                    state_d = (ld_len_eff > LEN_W'(1)) ? StBurst : StDrain;
                end
            end
            StBurst: begin
                if (!ld_req_i || gen_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Everything is forced quiet while reset is held.
    always_comb begin
        core_gnt  = 1'b0;
        ld_gnt    = 1'b0;
        ld_done   = 1'b0;
        mem_req   = '0;
        gen_load  = 1'b0;
        gen_step  = 1'b0;
        gen_clear = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (ld_win) begin
                        ld_gnt   = 1'b1;
                        gen_load = 1'b1;
                        mem_req  = dmem_access(ld_we_i, ld_addr_i, ld_wdata_i);
                    end else if (core_req_i) begin
                        core_gnt = 1'b1;
                        mem_req  = dmem_access(core_we_i, core_addr_i, core_wdata_i);
                    end
                end
                StBurst: begin
                    if (ld_req_i) begin
                        ld_gnt   = 1'b1;
                        gen_step = 1'b1;
                        mem_req  = dmem_access(dir_q, gen_addr, ld_wdata_i);
                    end else begin
                        gen_clear = 1'b1;
                    end
                end
                StDrain: begin
                    ld_done   = 1'b1;
                    gen_clear = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        starve_d  = starve_q;
        dir_d     = gen_load ? ld_we_i : dir_q;
        rd_pend_d = mem_req.en & ~mem_req.we;
        owner_d   = owner_q;
        if (ld_gnt || !ld_req_i) begin
            starve_d = '0;
        end else if (core_gnt && !starve_hit) begin
            starve_d = starve_q + SW'(1);
        end
        if (mem_req.en && !mem_req.we) begin
            owner_d = ld_gnt ? OwnLd : OwnCore;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q  <= '0;
            dir_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            owner_q   <= OwnCore;
        end else begin
            starve_q  <= starve_d;
            dir_q     <= dir_d;
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
        end
    end

    assign core_gnt_o    = core_gnt;
    assign ld_gnt_o      = ld_gnt;
    assign ld_done_o     = ld_done;
    assign core_stall_o  = ~reset & core_req_i & ~core_gnt;

    assign mem_en_o      = mem_req.en;
    assign mem_we_o      = mem_req.we;
    assign mem_addr_o    = mem_req.addr;
    assign mem_wdata_o   = mem_req.wdata;

    assign core_rvalid_o = ~reset & rd_pend_q & (owner_q == OwnCore);
    assign ld_rvalid_o   = ~reset & rd_pend_q & (owner_q == OwnLd);
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    assign ld_rdata_o    = ld_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts every
// memory access, stall, done pulse and read return; a monitor checks them.
module tb_dmem_arbiter;

    localparam int STARVE_MAX = 8;
    localparam int LEN_W      = 8;
    localparam int ADDR_STEP  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              core_req = 1'b0, core_we = 1'b0;
    logic [31:0]       core_addr = '0, core_wdata = '0;
    logic              core_gnt, core_stall, core_rvalid;
    logic [31:0]       core_rdata;
    logic              ld_req = 1'b0, ld_we = 1'b0;
    logic [31:0]       ld_addr = '0;
    logic [LEN_W-1:0]  ld_len = '0;
    logic [31:0]       ld_wdata = '0;
    logic              ld_gnt, ld_rvalid, ld_done;
    logic [31:0]       ld_rdata;
    logic              mem_en, mem_we;
    logic [31:0]       mem_addr, mem_wdata;
    logic [31:0]       mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .LEN_W      (LEN_W),
        .ADDR_STEP  (ADDR_STEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_req_i    (core_req),
        .core_we_i     (core_we),
        .core_addr_i   (core_addr),
        .core_wdata_i  (core_wdata),
        .core_gnt_o    (core_gnt),
        .core_stall_o  (core_stall),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .ld_req_i      (ld_req),
        .ld_we_i       (ld_we),
        .ld_addr_i     (ld_addr),
        .ld_len_i      (ld_len),
        .ld_wdata_i    (ld_wdata),
        .ld_gnt_o      (ld_gnt),
        .ld_rvalid_o   (ld_rvalid),
        .ld_rdata_o    (ld_rdata),
        .ld_done_o     (ld_done),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    // Read-only memory image: contents are a fixed function of the address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= (mem_en && !mem_we) ? mem_val(mem_addr) : $urandom;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          who;  // 1 = loader
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t q_mem[$];
    acc_t q_crd[$];
    acc_t q_lrd[$];
    int   q_stall[$];
    int   q_done[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, in transaction terms.
    bit          m_in_burst = 0;
    bit          m_drain = 0;
    int          m_left = 0;
    int          m_k = 0;
    int          m_starve = 0;
    logic [31:0] m_base = '0;
    bit          m_dir = 0;
    bit          m_rd_pend = 0;
    acc_t        m_rd;

    function automatic void model();
        acc_t a;
        bit   ld_g = 0, core_g = 0, next_drain = 0;
        int   len;
        if (reset) begin
            m_in_burst = 0;
            m_drain = 0;
            m_left = 0;
            m_starve = 0;
            m_rd_pend = 0;
            return;
        end
        if (m_rd_pend) begin
            a = m_rd;
            a.cyc = cyc;
            a.data = mem_val(a.addr);
            if (a.who) q_lrd.push_back(a);
            else q_crd.push_back(a);
            m_rd_pend = 0;
        end
        a.cyc = cyc;
        if (m_drain) begin
            q_done.push_back(cyc);
            m_drain = 0;
        end else if (m_in_burst) begin
            if (!ld_req) begin
                m_in_burst = 0;
                next_drain = 1;
            end else begin
                ld_g = 1;
                a.we = m_dir;
                a.addr = m_base + 32'(m_k * ADDR_STEP);
                m_k++;
                m_left--;
                if (m_left == 0) begin
                    m_in_burst = 0;
                    next_drain = 1;
                end
            end
        end else if (ld_req && (!core_req || m_starve == STARVE_MAX)) begin
            ld_g = 1;
            a.we = ld_we;
            a.addr = ld_addr;
            m_base = ld_addr;
            m_dir = ld_we;
            m_k = 1;
            len = (ld_len == 0) ? 1 : int'(ld_len);
            m_left = len - 1;
            if (m_left > 0) m_in_burst = 1;
            else next_drain = 1;
        end else if (core_req) begin
            core_g = 1;
            a.we = core_we;
            a.addr = core_addr;
        end
        if (ld_g || core_g) begin
            a.who = ld_g;
            a.data = ld_g ? ld_wdata : core_wdata;
            q_mem.push_back(a);
            if (!a.we) begin
                m_rd = a;
                m_rd_pend = 1;
            end
        end
        if (core_req && !core_g) q_stall.push_back(cyc);
        if (ld_g || !ld_req) m_starve = 0;
        else if (core_g) m_starve++;
        if (next_drain) m_drain = 1;
    endfunction

    task automatic drive(input bit rst, input bit creq, input bit cwe,
                         input logic [31:0] caddr, input bit lreq, input bit lwe,
                         input logic [31:0] laddr, input int llen);
        @(posedge clk);
        #1;
        reset = rst;
        core_req = creq;
        core_we = cwe;
        core_addr = caddr;
        core_wdata = $urandom;
        ld_req = lreq;
        ld_we = lwe;
        ld_addr = laddr;
        ld_len = LEN_W'(llen);
        ld_wdata = $urandom;
        model();
    endtask

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        acc_t a;
        int   c;
        if (reset) begin
            chk("reset_outputs",
                {core_gnt, core_stall, core_rvalid, core_rdata, ld_gnt, ld_rvalid, ld_rdata,
                 ld_done, mem_en, mem_we, mem_addr, mem_wdata}, '0);
        end else begin
            if (mem_en) begin
                if (q_mem.size() == 0) begin
                    chk("mem_unexpected", 1, 0);
                end else begin
                    a = q_mem.pop_front();
                    chk("mem_cycle", cyc, a.cyc);
                    chk("mem_grant", {core_gnt, ld_gnt}, a.who ? 2'b01 : 2'b10);
                    chk("mem_we", mem_we, a.we);
                    chk("mem_addr", mem_addr, a.addr);
                    chk("mem_wdata", mem_wdata, a.data);
                end
            end else begin
                chk("idle_bus", {core_gnt, ld_gnt, mem_we, mem_addr, mem_wdata}, '0);
            end
            if (core_stall) begin
                if (q_stall.size() == 0) chk("stall_unexpected", 1, 0);
                else begin
                    c = q_stall.pop_front();
                    chk("stall_cycle", cyc, c);
                end
            end
            if (ld_done) begin
                if (q_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    c = q_done.pop_front();
                    chk("done_cycle", cyc, c);
                end
            end
            if (core_rvalid) begin
                if (q_crd.size() == 0) chk("core_rvalid_unexpected", 1, 0);
                else begin
                    a = q_crd.pop_front();
                    chk("core_rd_cycle", cyc, a.cyc);
                    chk("core_rdata", core_rdata, a.data);
                end
            end else if (core_rdata !== '0) begin
                chk("core_rdata_idle", core_rdata, 0);
            end
            if (ld_rvalid) begin
                if (q_lrd.size() == 0) chk("ld_rvalid_unexpected", 1, 0);
                else begin
                    a = q_lrd.pop_front();
                    chk("ld_rd_cycle", cyc, a.cyc);
                    chk("ld_rdata", ld_rdata, a.data);
                end
            end else if (ld_rdata !== '0) begin
                chk("ld_rdata_idle", ld_rdata, 0);
            end
        end
    end

    initial begin : stim
        bit          lreq_s = 0;
        bit          lwe_s = 0;
        logic [31:0] laddr_s = '0;
        int          llen_s = 0;
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0);
        // Core load then store.
        drive(0, 1, 0, 32'h10, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h14, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Loader write burst of 4, core stalled behind it.
        drive(0, 0, 0, 0, 1, 1, 32'h100, 4);
        repeat (3) drive(0, 1, 1, 32'h20, 1, 1, 32'h100, 4);
        drive(0, 1, 1, 32'h20, 0, 0, 0, 0);
        drive(0, 1, 0, 32'h24, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Starvation: core wins eight times, then the loader.
        for (int i = 0; i < 9; i++) drive(0, 1, i[0], 32'h40 + 32'(4 * i), 1, 0, 32'h200, 1);
        drive(0, 1, 0, 32'h80, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Abort of a 10-beat read burst after 3 beats.
        drive(0, 0, 0, 0, 1, 0, 32'h300, 10);
        repeat (2) drive(0, 1, 0, 32'h30, 1, 0, 32'h300, 10);
        repeat (3) drive(0, 1, 0, 32'h30, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Zero length and address wrap.
        drive(0, 0, 0, 0, 1, 1, 32'h400, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 1, 0, 32'hFFFFFFFC, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset mid-burst with a read in flight.
        repeat (2) drive(0, 0, 0, 0, 1, 0, 32'h500, 6);
        drive(1, 1, 0, 32'h50, 1, 0, 32'h500, 6);
        drive(0, 1, 0, 32'h54, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (!lreq_s) begin
                lreq_s = ($urandom_range(0, 9) < 2);
                lwe_s = $urandom_range(0, 1) == 1;
                laddr_s = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
                llen_s = $urandom_range(0, 5);
            end else if ($urandom_range(0, 19) == 0) begin
                lreq_s = 0;
            end
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 1) == 1, $urandom & 32'hFFFFFFFC,
                  lreq_s, lwe_s, laddr_s, llen_s);
        end
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("leftover_mem", q_mem.size(), 0);
        chk("leftover_core_rd", q_crd.size(), 0);
        chk("leftover_ld_rd", q_lrd.size(), 0);
        chk("leftover_stall", q_stall.size(), 0);
        chk("leftover_done", q_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
